// File: rtl/imem_boot_loader_if.sv
// Load-stream and instruction-fetch signals of the boot-loading imem.
// master drives loads/fetches, slave is the memory.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                  ld_start;
    logic                  ld_valid;
    logic [7:0]            ld_byte;
    logic                  ld_ready;
    logic                  ld_done;
    logic [ADDR_WIDTH-2:0] ld_words;
    logic                  ld_ovf;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_err;

    modport master (
        output ld_start, ld_valid, ld_byte, ld_done,
        output if_req, if_addr,
        input  ld_ready, ld_words, ld_ovf,
        input  if_gnt, if_rvalid, if_rdata, if_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_byte, ld_done,
        input  if_req, if_addr,
        output ld_ready, ld_words, ld_ovf,
        output if_gnt, if_rvalid, if_rdata, if_err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory with a byte-stream boot loader.
// BOOT packs bytes into words; RUN serves 1-cycle registered fetches.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 2048,
    parameter int BIG_END    = 0
) (
    input logic               clk,
    input logic               rst_n,
    imem_boot_loader_if.slave bus
);
    localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH-2:0] WORDS_ONE = 1;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PTR_W-1:0]      wr_ptr;
    logic [1:0]            byte_cnt;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_nxt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  in_boot;
    logic                  acc;
    logic                  last_byte;
    logic                  flush;
    logic                  wr_en;

    logic [31:0]           fidx;
    logic                  f_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_fmt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Next state: a restart request always wins over finishing the load.
    always_comb begin
        state_d = state_q;
        if (bus.ld_start)
            state_d = BOOT;
        else if (state_q == BOOT && bus.ld_done)
            state_d = RUN;
    end

    assign in_boot      = (state_q == BOOT);
    assign bus.ld_ready = in_boot;
    assign acc          = in_boot & bus.ld_valid & ~bus.ld_start;
    assign last_byte    = acc & (byte_cnt == 2'd3);
    assign flush        = in_boot & ~bus.ld_start & bus.ld_done
                        & ((byte_cnt != 2'd0) | acc);
    assign wr_en        = last_byte | flush;

    // Merge the incoming byte into the word under assembly; unfilled bytes stay 0.
    always_comb begin
        word_nxt = word_q;
        if (acc)
            word_nxt[{byte_cnt, 3'b000} +: 8] = bus.ld_byte;
    end

    // Load pointer, byte counter, word count and overflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            byte_cnt     <= 2'd0;
            word_q       <= '0;
            bus.ld_words <= '0;
            bus.ld_ovf   <= 1'b0;
        end else if (bus.ld_start) begin
            wr_ptr       <= '0;
            byte_cnt     <= 2'd0;
            word_q       <= '0;
            bus.ld_words <= '0;
            bus.ld_ovf   <= 1'b0;
        end else if (wr_en) begin
            byte_cnt <= 2'd0;
            word_q   <= '0;
            if (bus.ld_words != '1)
                bus.ld_words <= bus.ld_words + WORDS_ONE;
            if (wr_ptr == PTR_LAST) begin
                wr_ptr     <= '0;
                bus.ld_ovf <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end else if (acc) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_q   <= word_nxt;
        end
    end

    // Memory array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[wr_ptr] <= word_nxt;
    end

    assign fidx    = 32'(bus.if_addr >> 2);
    assign f_err   = (bus.if_addr[1:0] != 2'b00) | (fidx >= 32'(MEM_DEPTH));
    assign rd_word = mem[fidx[PTR_W-1:0]];
    assign rd_fmt  = (BIG_END != 0) ? rd_word
                   : {rd_word[7:0], rd_word[15:8],
                      rd_word[23:16], rd_word[31:24]};
    assign bus.if_gnt = bus.if_req & (state_q == RUN);

    // Fetch response register; data and error hold when no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_err    <= 1'b0;
        end else if (bus.if_gnt) begin
            bus.if_rvalid <= 1'b1;
            bus.if_err    <= f_err;
            bus.if_rdata  <= f_err ? '0 : rd_fmt;
        end else begin
            bus.if_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: two instances,
// little-endian output (depth 4, 14-bit addr) and big-endian output.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    logic        g;
    logic        rv;
    logic        er;
    logic [31:0] rd;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus_a ();
    imem_boot_loader_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus_b ();

    imem_boot_loader #(
        .ADDR_WIDTH(14), .DATA_WIDTH(32), .MEM_DEPTH(4), .BIG_END(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );

    imem_boot_loader #(
        .ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_DEPTH(2048), .BIG_END(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    task automatic send_a(input logic [7:0] b);
        bus_a.ld_valid = 1'b1;
        bus_a.ld_byte  = b;
        @(negedge clk);
        bus_a.ld_valid = 1'b0;
    endtask

    task automatic send_word_a(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_a(w[8*i +: 8]);
    endtask

    task automatic done_a();
        bus_a.ld_done = 1'b1;
        @(negedge clk);
        bus_a.ld_done = 1'b0;
    endtask

    task automatic start_a();
        bus_a.ld_start = 1'b1;
        @(negedge clk);
        bus_a.ld_start = 1'b0;
    endtask

    task automatic fetch_a(input logic [13:0] addr);
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = addr;
        #1 g = bus_a.if_gnt;
        @(negedge clk);
        bus_a.if_req = 1'b0;
        rv = bus_a.if_rvalid;
        rd = bus_a.if_rdata;
        er = bus_a.if_err;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (bus_a.ld_ready !== 1'b1 || bus_a.ld_words !== 13'd0
            || bus_a.ld_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ld: ready=%b words=%0d ovf=%b want 1/0/0",
                     bus_a.ld_ready, bus_a.ld_words, bus_a.ld_ovf);
        end
        vectors++;
        if (bus_a.if_rvalid !== 1'b0 || bus_a.if_rdata !== 32'h0
            || bus_a.if_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_if: rv=%b data=%h err=%b want 0/0/0",
                     bus_a.if_rvalid, bus_a.if_rdata, bus_a.if_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        logic [7:0] bytes [8];
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 8; i++) send_a(bytes[i]);
        vectors++;
        if (bus_a.ld_words !== 13'd2) begin
            miscompares++;
            $display("FAIL load_words: got %0d want 2", bus_a.ld_words);
        end
        done_a();
        vectors++;
        if (bus_a.ld_ready !== 1'b0 || bus_a.ld_words !== 13'd2) begin
            miscompares++;
            $display("FAIL load_run: ready=%b words=%0d want 0/2",
                     bus_a.ld_ready, bus_a.ld_words);
        end
    endtask

    task automatic test_back_to_back();
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = 14'h000;
        #1;
        vectors++;
        if (bus_a.if_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_gnt: got %b want 1", bus_a.if_gnt);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.if_rvalid !== 1'b1 || bus_a.if_rdata !== 32'h78563412
            || bus_a.if_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: rv=%b data=%h err=%b want 1/78563412/0",
                     bus_a.if_rvalid, bus_a.if_rdata, bus_a.if_err);
        end
        bus_a.if_addr = 14'h004;
        @(negedge clk);
        bus_a.if_req = 1'b0;
        vectors++;
        if (bus_a.if_rvalid !== 1'b1 || bus_a.if_rdata !== 32'hEFBEADDE
            || bus_a.if_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: rv=%b data=%h err=%b want 1/efbeadde/0",
                     bus_a.if_rvalid, bus_a.if_rdata, bus_a.if_err);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.if_rvalid !== 1'b0 || bus_a.if_rdata !== 32'hEFBEADDE) begin
            miscompares++;
            $display("FAIL b2b_hold: rv=%b data=%h want 0/efbeadde",
                     bus_a.if_rvalid, bus_a.if_rdata);
        end
        send_a(8'hFF);
        vectors++;
        if (bus_a.ld_words !== 13'd2 || bus_a.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL run_byte_ignored: words=%0d ready=%b want 2/0",
                     bus_a.ld_words, bus_a.ld_ready);
        end
    endtask

    task automatic test_partial();
        start_a();
        vectors++;
        if (bus_a.ld_ready !== 1'b1 || bus_a.ld_words !== 13'd0) begin
            miscompares++;
            $display("FAIL restart: ready=%b words=%0d want 1/0",
                     bus_a.ld_ready, bus_a.ld_words);
        end
        send_a(8'hAA);
        send_a(8'hBB);
        send_a(8'hCC);
        fetch_a(14'h000);
        vectors++;
        if (g !== 1'b0 || rv !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_fetch: gnt=%b rv=%b want 0/0", g, rv);
        end
        done_a();
        vectors++;
        if (bus_a.ld_words !== 13'd1) begin
            miscompares++;
            $display("FAIL partial_words: got %0d want 1", bus_a.ld_words);
        end
        fetch_a(14'h000);
        vectors++;
        if (rv !== 1'b1 || rd !== 32'hAABBCC00 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_data: rv=%b data=%h err=%b want 1/aabbcc00/0",
                     rv, rd, er);
        end
        fetch_a(14'h004);
        vectors++;
        if (rd !== 32'hEFBEADDE) begin
            miscompares++;
            $display("FAIL mem1_kept: got %h want efbeadde", rd);
        end
        start_a();
        send_a(8'h11);
        bus_a.ld_valid = 1'b1;
        bus_a.ld_byte  = 8'h22;
        bus_a.ld_done  = 1'b1;
        @(negedge clk);
        bus_a.ld_valid = 1'b0;
        bus_a.ld_done  = 1'b0;
        vectors++;
        if (bus_a.ld_words !== 13'd1 || bus_a.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL done_with_byte: words=%0d ready=%b want 1/0",
                     bus_a.ld_words, bus_a.ld_ready);
        end
        fetch_a(14'h000);
        vectors++;
        if (rd !== 32'h11220000) begin
            miscompares++;
            $display("FAIL done_with_byte_data: got %h want 11220000", rd);
        end
    endtask

    task automatic test_err();
        logic [13:0] addrs [3];
        addrs = '{14'h0002, 14'h2000, 14'h0010};
        for (int i = 0; i < 3; i++) begin
            fetch_a(addrs[i]);
            vectors++;
            if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
                miscompares++;
                $display("FAIL err_%0h: rv=%b err=%b data=%h want 1/1/0",
                         addrs[i], rv, er, rd);
            end
        end
        fetch_a(14'h000);
        vectors++;
        if (er !== 1'b0 || rd !== 32'h11220000) begin
            miscompares++;
            $display("FAIL err_clear: err=%b data=%h want 0/11220000", er, rd);
        end
    endtask

    task automatic test_wrap();
        start_a();
        for (int k = 0; k < 5; k++) begin
            send_word_a(32'hA0B0C0D0 + 32'(k));
            if (k == 2) begin
                vectors++;
                if (bus_a.ld_ovf !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_early: got %b want 0", bus_a.ld_ovf);
                end
            end
            if (k == 3) begin
                vectors++;
                if (bus_a.ld_ovf !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovf_set: got %b want 1", bus_a.ld_ovf);
                end
            end
        end
        vectors++;
        if (bus_a.ld_words !== 13'd5 || bus_a.ld_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_cnt: words=%0d ovf=%b want 5/1",
                     bus_a.ld_words, bus_a.ld_ovf);
        end
        done_a();
        fetch_a(14'h000);
        vectors++;
        if (rd !== 32'hD4C0B0A0) begin
            miscompares++;
            $display("FAIL wrap_mem0: got %h want d4c0b0a0", rd);
        end
        fetch_a(14'h00C);
        vectors++;
        if (rd !== 32'hD3C0B0A0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_mem3: data=%h err=%b want d3c0b0a0/0", rd, er);
        end
        fetch_a(14'h004);
        vectors++;
        if (rd !== 32'hD1C0B0A0) begin
            miscompares++;
            $display("FAIL wrap_mem1: got %h want d1c0b0a0", rd);
        end
        start_a();
        vectors++;
        if (bus_a.ld_ovf !== 1'b0 || bus_a.ld_words !== 13'd0) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b words=%0d want 0/0",
                     bus_a.ld_ovf, bus_a.ld_words);
        end
    endtask

    task automatic test_reset_mid();
        send_a(8'h99);
        send_a(8'h88);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word_a(32'h04030201);
        vectors++;
        if (bus_a.ld_words !== 13'd1) begin
            miscompares++;
            $display("FAIL rst_mid_words: got %0d want 1", bus_a.ld_words);
        end
        done_a();
        fetch_a(14'h000);
        vectors++;
        if (rd !== 32'h01020304) begin
            miscompares++;
            $display("FAIL rst_mid_data: got %h want 01020304", rd);
        end
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = 14'h004;
        @(posedge clk);
        #1 bus_a.if_req = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_a.if_rvalid !== 1'b0 || bus_a.if_rdata !== 32'h0
            || bus_a.ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_fetch: rv=%b data=%h ready=%b want 0/0/1",
                     bus_a.if_rvalid, bus_a.if_rdata, bus_a.ld_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_inflight();
        done_a();
        bus_a.if_req   = 1'b1;
        bus_a.if_addr  = 14'h000;
        bus_a.ld_start = 1'b1;
        #1;
        vectors++;
        if (bus_a.if_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL inflight_gnt: got %b want 1", bus_a.if_gnt);
        end
        @(negedge clk);
        bus_a.if_req   = 1'b0;
        bus_a.ld_start = 1'b0;
        vectors++;
        if (bus_a.if_rvalid !== 1'b1 || bus_a.if_rdata !== 32'h01020304
            || bus_a.ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL inflight_rsp: rv=%b data=%h ready=%b want 1/01020304/1",
                     bus_a.if_rvalid, bus_a.if_rdata, bus_a.ld_ready);
        end
    endtask

    task automatic test_start_beats_done();
        send_a(8'h77);
        send_a(8'h66);
        bus_a.ld_start = 1'b1;
        bus_a.ld_done  = 1'b1;
        @(negedge clk);
        bus_a.ld_start = 1'b0;
        bus_a.ld_done  = 1'b0;
        vectors++;
        if (bus_a.ld_ready !== 1'b1 || bus_a.ld_words !== 13'd0) begin
            miscompares++;
            $display("FAIL start_wins: ready=%b words=%0d want 1/0",
                     bus_a.ld_ready, bus_a.ld_words);
        end
        send_word_a(32'h11223344);
        done_a();
        fetch_a(14'h000);
        vectors++;
        if (rd !== 32'h44332211) begin
            miscompares++;
            $display("FAIL start_wins_data: got %h want 44332211", rd);
        end
    endtask

    task automatic test_big_end();
        logic [7:0] bytes [4];
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 4; i++) begin
            bus_b.ld_valid = 1'b1;
            bus_b.ld_byte  = bytes[i];
            @(negedge clk);
        end
        bus_b.ld_valid = 1'b0;
        bus_b.ld_done  = 1'b1;
        @(negedge clk);
        bus_b.ld_done = 1'b0;
        vectors++;
        if (bus_b.ld_words !== 10'd1) begin
            miscompares++;
            $display("FAIL be_words: got %0d want 1", bus_b.ld_words);
        end
        bus_b.if_req  = 1'b1;
        bus_b.if_addr = 11'h000;
        @(negedge clk);
        vectors++;
        if (bus_b.if_rvalid !== 1'b1 || bus_b.if_rdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL be_data: rv=%b data=%h want 1/12345678",
                     bus_b.if_rvalid, bus_b.if_rdata);
        end
        bus_b.if_addr = 11'h001;
        @(negedge clk);
        bus_b.if_req = 1'b0;
        vectors++;
        if (bus_b.if_err !== 1'b1 || bus_b.if_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL be_misalign: err=%b data=%h want 1/0",
                     bus_b.if_err, bus_b.if_rdata);
        end
    endtask

    initial begin
        bus_a.ld_start = 1'b0;
        bus_a.ld_valid = 1'b0;
        bus_a.ld_byte  = 8'h0;
        bus_a.ld_done  = 1'b0;
        bus_a.if_req   = 1'b0;
        bus_a.if_addr  = '0;
        bus_b.ld_start = 1'b0;
        bus_b.ld_valid = 1'b0;
        bus_b.ld_byte  = 8'h0;
        bus_b.ld_done  = 1'b0;
        bus_b.if_req   = 1'b0;
        bus_b.if_addr  = '0;
        test_reset();
        test_load();
        test_back_to_back();
        test_partial();
        test_err();
        test_wrap();
        test_reset_mid();
        test_start_inflight();
        test_start_beats_done();
        test_big_end();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
